// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  // Number of registers addressed by aw address bits.
  function automatic int unsigned rf_depth(int unsigned aw);
    return 32'(1) << aw;
  endfunction

  // Low bit of packed port i when each port is w bits wide.
  function automatic int unsigned rf_slice_lo(int unsigned i, int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: stored value, write forwarding, hard-wired zero register.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned FWD     = 1
) (
  input  logic [rf_depth(ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                        raddr,
  input  logic                                     fwd_a_en,
  input  logic [ADDR_W-1:0]                        fwd_a_addr,
  input  logic [DATA_W-1:0]                        fwd_a_data,
  input  logic                                     fwd_b_en,
  input  logic [ADDR_W-1:0]                        fwd_b_addr,
  input  logic [DATA_W-1:0]                        fwd_b_data,
  output logic [DATA_W-1:0]                        rdata_c
);

  // Port A is applied last so it overrides port B on a shared address.
  always_comb begin
    rdata_c = mem[raddr];
    if (FWD != 0) begin
      if (fwd_b_en && (fwd_b_addr == raddr)) rdata_c = fwd_b_data;
      if (fwd_a_en && (fwd_a_addr == raddr)) rdata_c = fwd_a_data;
    end
    if ((ZERO_R0 != 0) && (raddr == '0)) rdata_c = '0;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD read ports,
// and a one-entry-per-cycle clear sweep.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned FWD     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_a,
  input  logic [ADDR_W-1:0]          waddr_a,
  input  logic [DATA_W-1:0]          wdata_a,
  input  logic                       we_b,
  input  logic [ADDR_W-1:0]          waddr_b,
  input  logic [DATA_W-1:0]          wdata_b,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       wr_drop
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  rf_state_e                    state;
  logic [ADDR_W-1:0]            ptr;

  logic idle_c, zero_a_c, zero_b_c, same_addr_c;
  logic acc_a_c, acc_b_c, drop_c;

  // Write arbitration: A beats B on a shared address; nothing is accepted mid-sweep.
  always_comb begin
    idle_c      = (state == IDLE);
    zero_a_c    = (ZERO_R0 != 0) && (waddr_a == '0);
    zero_b_c    = (ZERO_R0 != 0) && (waddr_b == '0);
    same_addr_c = (waddr_a == waddr_b);
    acc_a_c     = idle_c && we_a && !zero_a_c;
    acc_b_c     = idle_c && we_b && !zero_b_c && !(we_a && same_addr_c);
    drop_c      = idle_c ? (we_a && we_b && same_addr_c && !zero_a_c)
                         : (we_a || we_b);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem     <= '0;
      state   <= IDLE;
      ptr     <= '0;
      busy    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= drop_c;
      case (state)
        IDLE: begin
          if (acc_a_c) mem[waddr_a] <= wdata_a;
          if (acc_b_c) mem[waddr_b] <= wdata_b;
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          // Terminal entry found by compare so ADDR_W=1 behaves like any other width.
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .FWD    (FWD)
    ) u_rd (
      .mem       (mem),
      .raddr     (raddr[rf_slice_lo(i, ADDR_W) +: ADDR_W]),
      .fwd_a_en  (acc_a_c),
      .fwd_a_addr(waddr_a),
      .fwd_a_data(wdata_a),
      .fwd_b_en  (acc_b_c),
      .fwd_b_addr(waddr_b),
      .fwd_b_data(wdata_b),
      .rdata_c   (rdata[rf_slice_lo(i, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: four configurations driven in lockstep against a reference model.
module tb_reg_file_mp;

  logic       clk = 1'b0;
  logic       rst_n, we_a, we_b, clr;
  logic [1:0] wa, wb;
  logic [7:0] wda, wdb;
  logic [3:0] ra;
  logic [15:0] rd0, rd1, rd2;
  logic [7:0]  rd3;
  logic [3:0]  bz, dr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // cfg0: default, cfg1: FWD=0, cfg2: ZERO_R0=1, cfg3: ADDR_W=1 with one read port
  reg_file_mp #(.DATA_W(8), .ADDR_W(2), .NUM_RD(2), .ZERO_R0(0), .FWD(1)) u0 (
    .clk(clk), .rst_n(rst_n), .we_a(we_a), .waddr_a(wa), .wdata_a(wda),
    .we_b(we_b), .waddr_b(wb), .wdata_b(wdb), .raddr(ra), .rdata(rd0),
    .clr_req(clr), .busy(bz[0]), .wr_drop(dr[0]));
  reg_file_mp #(.DATA_W(8), .ADDR_W(2), .NUM_RD(2), .ZERO_R0(0), .FWD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .we_a(we_a), .waddr_a(wa), .wdata_a(wda),
    .we_b(we_b), .waddr_b(wb), .wdata_b(wdb), .raddr(ra), .rdata(rd1),
    .clr_req(clr), .busy(bz[1]), .wr_drop(dr[1]));
  reg_file_mp #(.DATA_W(8), .ADDR_W(2), .NUM_RD(2), .ZERO_R0(1), .FWD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .we_a(we_a), .waddr_a(wa), .wdata_a(wda),
    .we_b(we_b), .waddr_b(wb), .wdata_b(wdb), .raddr(ra), .rdata(rd2),
    .clr_req(clr), .busy(bz[2]), .wr_drop(dr[2]));
  reg_file_mp #(.DATA_W(8), .ADDR_W(1), .NUM_RD(1), .ZERO_R0(0), .FWD(1)) u3 (
    .clk(clk), .rst_n(rst_n), .we_a(we_a), .waddr_a(wa[0]), .wdata_a(wda),
    .we_b(we_b), .waddr_b(wb[0]), .wdata_b(wdb), .raddr(ra[0:0]), .rdata(rd3),
    .clr_req(clr), .busy(bz[3]), .wr_drop(dr[3]));

  // Reference model: array contents, cycles left in a sweep, sweep position, pending drop flag.
  logic [7:0] m_mem [4][4];
  int         m_left [4];
  int         m_pos  [4];
  bit         m_drop [4];

  function automatic int depth(int c);  return (c == 3) ? 2 : 4; endfunction
  function automatic int nrd(int c);    return (c == 3) ? 1 : 2; endfunction
  function automatic bit fwd(int c);    return c != 1;           endfunction
  function automatic bit zr(int c);     return c == 2;           endfunction
  function automatic int ad(int c, logic [1:0] a);
    return (c == 3) ? int'(a[0]) : int'(a);
  endfunction

  function automatic logic [7:0] exp_rd(int c, int a);
    if (zr(c) && a == 0) return 8'h00;
    if (fwd(c) && m_left[c] == 0) begin
      if (we_a && ad(c, wa) == a) return wda;
      if (we_b && ad(c, wb) == a && !(zr(c) && a == 0)) return wdb;
    end
    return m_mem[c][a];
  endfunction

  function automatic logic [7:0] obs_rd(int c, int p);
    case (c)
      0:       return rd0[p*8 +: 8];
      1:       return rd1[p*8 +: 8];
      2:       return rd2[p*8 +: 8];
      default: return rd3;
    endcase
  endfunction

  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cfg%0d observed=%02h expected=%02h", tag, c, obs, exp);
    end
  endtask

  // Compare every output of every instance against the model, away from the edge.
  task automatic sample();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < nrd(c); p++)
        chk("rdata", c, obs_rd(c, p), exp_rd(c, ad(c, ra[p*2 +: 2])));
      chk("busy", c, 8'(bz[c]), 8'(m_left[c] > 0));
      chk("wr_drop", c, 8'(dr[c]), 8'(m_drop[c]));
    end
  endtask

  // Clock edge, then apply the same edge to the model.
  task automatic advance();
    int a, b;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      a = ad(c, wa);
      b = ad(c, wb);
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) m_mem[c][k] = 8'h00;
        m_left[c] = 0;
        m_pos[c]  = 0;
        m_drop[c] = 1'b0;
      end else if (m_left[c] > 0) begin
        m_drop[c] = we_a || we_b;
        m_mem[c][m_pos[c]] = 8'h00;
        m_pos[c]++;
        m_left[c]--;
      end else begin
        m_drop[c] = we_a && we_b && a == b && !(zr(c) && a == 0);
        if (we_b && !(zr(c) && b == 0)) m_mem[c][b] = wdb;
        if (we_a && !(zr(c) && a == 0)) m_mem[c][a] = wda;
        if (clr) begin
          m_left[c] = depth(c);
          m_pos[c]  = 0;
        end
      end
    end
    #1;
  endtask

  task automatic quiet();
    rst_n = 1'b1; we_a = 1'b0; we_b = 1'b0; clr = 1'b0;
    wa = 2'd0; wb = 2'd0; wda = 8'h00; wdb = 8'h00;
  endtask

  initial begin
    int cnt0, cnt3;
    quiet();
    ra = 4'h0;
    rst_n = 1'b0;
    advance();

    // Reset state on all addresses
    rst_n = 1'b1; ra = {2'd1, 2'd0}; sample(); advance();
    ra = {2'd3, 2'd2}; sample(); advance();

    // Same-cycle forwarding versus registered read
    we_a = 1'b1; wa = 2'd2; wda = 8'hA5; ra = {2'd0, 2'd2};
    sample();
    chk("fwd_same_cycle", 0, rd0[7:0], 8'hA5);
    chk("nofwd_same_cycle", 1, rd1[7:0], 8'h00);
    advance();
    quiet(); sample();
    chk("nofwd_next_cycle", 1, rd1[7:0], 8'hA5);
    advance();

    // Collision on address 1: A wins, one-cycle drop pulse
    we_a = 1'b1; we_b = 1'b1; wa = 2'd1; wb = 2'd1; wda = 8'h11; wdb = 8'h22; ra = {2'd1, 2'd1};
    sample(); advance();
    quiet(); sample();
    chk("collision_a_wins", 0, rd0[7:0], 8'h11);
    chk("collision_drop", 0, 8'(dr[0]), 8'h01);
    advance();
    sample();
    chk("collision_drop_clears", 0, 8'(dr[0]), 8'h00);
    advance();

    // Fill 0x01..0x04 then sweep
    we_a = 1'b1; we_b = 1'b1; wa = 2'd0; wda = 8'h01; wb = 2'd1; wdb = 8'h02;
    sample(); advance();
    wa = 2'd2; wda = 8'h03; wb = 2'd3; wdb = 8'h04; ra = {2'd3, 2'd2};
    sample(); advance();
    quiet(); clr = 1'b1; ra = {2'd1, 2'd0};
    sample(); advance();
    cnt0 = 0; cnt3 = 0;
    for (int k = 0; k < 6; k++) begin
      quiet();
      if (k == 0) begin we_a = 1'b1; wa = 2'd3; wda = 8'h77; end
      ra = {2'd3, 2'(k)};
      sample();
      if (bz[0]) cnt0++;
      if (bz[3]) cnt3++;
      advance();
    end
    chk("sweep_len_depth4", 0, 8'(cnt0), 8'd4);
    chk("sweep_len_depth2", 3, 8'(cnt3), 8'd2);
    ra = {2'd3, 2'd3}; sample();
    chk("sweep_dropped_write", 0, rd0[7:0], 8'h00);
    advance();

    // Zero register ignores writes, including the forwarding path
    we_a = 1'b1; wa = 2'd0; wda = 8'hFF; ra = {2'd0, 2'd0};
    sample();
    chk("zero_fwd", 2, rd2[7:0], 8'h00);
    advance();
    quiet(); sample();
    chk("zero_stored", 2, rd2[7:0], 8'h00);
    chk("zero_no_drop", 2, 8'(dr[2]), 8'h00);
    advance();

    // Reset in the middle of a sweep
    we_a = 1'b1; wa = 2'd2; wda = 8'h3C; sample(); advance();
    quiet(); clr = 1'b1; sample(); advance();
    quiet(); sample(); advance();
    rst_n = 1'b0; sample(); advance();
    quiet(); ra = {2'd3, 2'd2}; sample();
    chk("reset_aborts_sweep", 0, 8'(bz[0]), 8'h00);
    we_a = 1'b1; wa = 2'd1; wda = 8'h5A; advance();
    quiet(); ra = {2'd2, 2'd1}; sample();
    chk("write_after_reset", 0, rd0[7:0], 8'h5A);
    advance();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(59) != 0);
      clr   = ($urandom_range(11) == 0);
      we_a  = 1'($urandom_range(1));
      we_b  = 1'($urandom_range(1));
      wa    = 2'($urandom_range(3));
      wb    = 2'($urandom_range(3));
      wda   = 8'($urandom);
      wdb   = 8'($urandom);
      ra    = 4'($urandom);
      sample();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file, the successor to the 4x8 single-write file.
- Provides configurable width and depth, two write ports with fixed priority, and NUM_RD combinational read ports with optional write-forwarding.
- Includes an optional hard-wired zero register and a sequenced clear engine, with a busy flag, that zeroes the array one entry per cycle.
- Sits between the datapath ALU and the instruction decoder as the architectural register store.

Parameters:
DATA_W, 8, bits per register
ADDR_W, 2, address bits; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes
FWD, 1, 1 = a read of an address being written this cycle returns the new write data

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
we_a  in  1  write enable, port A (high priority)
waddr_a  in  ADDR_W  write address A
wdata_a  in  DATA_W  write data A
we_b  in  1  write enable, port B
waddr_b  in  ADDR_W  write address B
wdata_b  in  DATA_W  write data B
raddr  in  NUM_RD*ADDR_W  packed read addresses; port i uses slice [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data, same packing
clr_req  in  1  pulse to start a clear sweep
busy  out  1  clear sweep in progress
wr_drop  out  1  registered; 1 = a write was discarded last cycle (collision or busy)

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All registers become 0.
  - FSM goes to IDLE; clear pointer = 0.
  - busy=0, wr_drop=0.
  - Reset has priority over everything, including a sweep in progress; an aborted sweep is not resumed.
- Reads:
  - Combinational, zero latency.
  - rdata[i] = reg[raddr[i]], except:
    - ZERO_R0=1 and raddr[i]=0 gives 0.
    - FWD=1 and an accepted write to raddr[i] this cycle gives that write's data; if both ports target the address, port A's data is returned.
  - During CLEAR, reads return stored contents; forwarding is disabled because no writes are accepted.
- Writes (IDLE only):
  - On the edge, reg[waddr_a] <= wdata_a if we_a; reg[waddr_b] <= wdata_b if we_b.
  - If both enables are high and the addresses are equal, A wins, B is discarded, and wr_drop=1 next cycle.
  - Writes to register 0 with ZERO_R0=1 are silently ignored; wr_drop is not set.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR with ptr=0 and busy=1 from the next cycle. Writes presented in the same cycle as clr_req are still performed.
  - CLEAR: reg[ptr] <= 0 and ptr <= ptr+1 each cycle.
    - When ptr = DEPTH-1, go to IDLE; busy=0 the cycle after the last entry is cleared.
    - A sweep takes exactly DEPTH cycles.
    - Any we_a/we_b asserted in CLEAR is dropped and wr_drop=1 next cycle.
    - clr_req in CLEAR is ignored; there is no restart.
- Width and ptr rules:
  - ptr is ADDR_W bits; terminal detection is by comparison, never by wrap.
  - DEPTH is not required to exceed 2; ADDR_W=1 must work.
- busy and wr_drop are registered outputs; no output depends combinationally on clr_req.

Decomposition:
- Shared package rf_pkg holds:
  - FSM state enum (IDLE, CLEAR)
  - the function computing DEPTH from ADDR_W
  - a read-port slice helper
- One sub-module, rf_read_port: a single read mux with forwarding and zero-register logic, instantiated NUM_RD times via generate.
- The storage array, write arbitration and clear FSM stay in the top module.

Test Plan:
- Reset then read all 4 addrs (DATA_W=8) -> every rdata = 0x00; busy=0, wr_drop=0.
- Basic write/read and forwarding:
  - we_a, waddr_a=2, wdata_a=0xA5, raddr0=2 in the same cycle -> rdata0=0xA5 combinationally (FWD=1).
  - With FWD=0 -> rdata0=0x00 that cycle and 0xA5 the next cycle.
- Collision: we_a=we_b=1, both addr 1, A=0x11, B=0x22 -> reg1 reads 0x11; wr_drop=1 for exactly one cycle.
- Clear sweep:
  - Fill regs with 0x01..0x04, pulse clr_req.
  - busy=1 for exactly 4 cycles; the entries read 0 in order 0,1,2,3.
  - we_a to addr 3 during the sweep is dropped (reg3=0) and wr_drop pulses.
- ZERO_R0=1: write 0xFF to addr 0 -> rdata reads 0; wr_drop stays 0; forwarding path also returns 0.
- Reset mid-sweep: rst_n low at sweep cycle 2 -> next cycle busy=0, all regs 0, IDLE; a write the following cycle is accepted normally.
